// File: rtl/rstn_seq_gen.sv
// Staged reset sequencer.
// Drives NUM_STAGES active-low resets that all assert together, stay low for
// HOLD_CYCLES, and then release one stage at a time, STAGE_GAP cycles apart.
// A sequence is started by the external reset, by a one-cycle software
// request, or by a debounced press of an asynchronous reset button.
module rstn_seq_gen #(
    parameter int NUM_STAGES      = 3,
    parameter int HOLD_CYCLES     = 16,
    parameter int STAGE_GAP       = 8,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  sw_rst_req,
    input  logic                  key_n,
    output logic [NUM_STAGES-1:0] rstn_out,
    output logic                  rst_busy,
    output logic                  rst_done
);

    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int GW = $clog2(STAGE_GAP + 1);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(STAGE_GAP - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);

    localparam logic [NUM_STAGES-1:0] FIRST_STAGE = NUM_STAGES'(1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ASSERT  = 2'd1;
    localparam logic [1:0] RELEASE = 2'd2;

    // Key path state
    logic          sync1_q, sync2_q;
    logic          keyLvl_q, keyLvl_d;
    logic [DW-1:0] dbCnt_q, dbCnt_d;
    logic          keyEvt_q, keyEvt_d;

    // Sequencer state
    logic [1:0]            state_q, state_d;
    logic [HW-1:0]         holdCnt_q, holdCnt_d;
    logic [GW-1:0]         gapCnt_q, gapCnt_d;
    logic [NUM_STAGES-1:0] rstnOut_q, rstnOut_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic request;

    // Two-flop synchronizer for the raw button; idles high (not pressed).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
        end
    end

    // Accept a new key level only after it has differed for DEBOUNCE_CYCLES in a row.
    always_comb begin
        keyLvl_d = keyLvl_q;
        dbCnt_d  = dbCnt_q;
        if (sync2_q == keyLvl_q) begin
            dbCnt_d = '0;
        end else if (dbCnt_q == DB_LAST) begin
            keyLvl_d = sync2_q;
            dbCnt_d  = '0;
        end else begin
            dbCnt_d = dbCnt_q + 1'b1;
        end
        keyEvt_d = keyLvl_q & ~keyLvl_d;
    end

    // Debounce registers; the press event is a one-cycle pulse on the 1->0 accept.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            keyLvl_q <= 1'b1;
            dbCnt_q  <= '0;
            keyEvt_q <= 1'b0;
        end else begin
            keyLvl_q <= keyLvl_d;
            dbCnt_q  <= dbCnt_d;
            keyEvt_q <= keyEvt_d;
        end
    end

    assign request = sw_rst_req | keyEvt_q;

    // Sequencer next state: a request always restarts the hold phase from zero.
    always_comb begin
        state_d   = state_q;
        holdCnt_d = holdCnt_q;
        gapCnt_d  = gapCnt_q;
        rstnOut_d = rstnOut_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        if (request) begin
            state_d   = ASSERT;
            holdCnt_d = '0;
            gapCnt_d  = '0;
            rstnOut_d = '0;
            busy_d    = 1'b1;
        end else begin
            case (state_q)
                ASSERT: begin
                    if (holdCnt_q == HOLD_LAST) begin
                        rstnOut_d = FIRST_STAGE;
                        gapCnt_d  = '0;
                        if (&rstnOut_d) begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            state_d = RELEASE;
                        end
                    end else begin
                        holdCnt_d = holdCnt_q + 1'b1;
                    end
                end
                RELEASE: begin
                    if (gapCnt_q == GAP_LAST) begin
                        rstnOut_d = (rstnOut_q << 1) | FIRST_STAGE;
                        gapCnt_d  = '0;
                        if (&rstnOut_d) begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    end else begin
                        gapCnt_d = gapCnt_q + 1'b1;
                    end
                end
                IDLE: begin
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Sequencer registers; reset parks the block at the start of the hold phase.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ASSERT;
            holdCnt_q <= '0;
            gapCnt_q  <= '0;
            rstnOut_q <= '0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            holdCnt_q <= holdCnt_d;
            gapCnt_q  <= gapCnt_d;
            rstnOut_q <= rstnOut_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign rstn_out = rstnOut_q;
    assign rst_busy = busy_q;
    assign rst_done = done_q;

endmodule

// File: tb/tb_rstn_seq_gen.sv
// Bench for rstn_seq_gen: directed scenarios plus random key/software traffic,
// compared every cycle against a timeline model of the reset sequence.
module tb_rstn_seq_gen;

    localparam int NS   = 3;
    localparam int HOLD = 4;
    localparam int GAP  = 2;
    localparam int DB   = 5;
    localparam int T_DONE = HOLD + (NS - 1) * GAP;

    logic          clk = 1'b0;
    logic          rstn;
    logic          sw_rst_req;
    logic          key_n;
    logic [NS-1:0] rstn_out;
    logic          rst_busy;
    logic          rst_done;

    int checks = 0;
    int errors = 0;
    int doneSeen = 0;

    // Model: sequence timeline and key debounce
    bit mActive;
    int mT;
    bit mDone;
    bit mS1, mS2, mLvl, mEvt;
    int mRun;

    rstn_seq_gen #(
        .NUM_STAGES(NS),
        .HOLD_CYCLES(HOLD),
        .STAGE_GAP(GAP),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .sw_rst_req(sw_rst_req),
        .key_n(key_n),
        .rstn_out(rstn_out),
        .rst_busy(rst_busy),
        .rst_done(rst_done)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Expected staged outputs from the time elapsed since the sequence started
    function automatic logic [NS-1:0] expOut();
        int n;
        if (!mActive) return {NS{1'b1}};
        if (mT < HOLD) return '0;
        n = 1 + (mT - HOLD) / GAP;
        if (n > NS) n = NS;
        return NS'((1 << n) - 1);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic checkCycle();
        checkOutput("rstn_out", 32'(rstn_out), 32'(expOut()));
        checkOutput("rst_busy", 32'(rst_busy), 32'(mActive));
        checkOutput("rst_done", 32'(rst_done), 32'(mDone));
        if (rst_done === 1'b1) doneSeen++;
    endtask

    task automatic modelReset();
        mActive = 1'b1;
        mT      = 0;
        mDone   = 1'b0;
        mS1     = 1'b1;
        mS2     = 1'b1;
        mLvl    = 1'b1;
        mEvt    = 1'b0;
        mRun    = 0;
    endtask

    // Predict the state after the next rising edge for the given inputs
    task automatic modelStep(input bit k, input bit s);
        bit req;
        bit newLvl;
        req    = s | mEvt;
        newLvl = mLvl;
        if (mS2 == mLvl) begin
            mRun = 0;
        end else begin
            mRun++;
            if (mRun == DB) begin
                newLvl = mS2;
                mRun   = 0;
            end
        end
        mEvt = mLvl & ~newLvl;
        mLvl = newLvl;
        mS2  = mS1;
        mS1  = k;
        mDone = 1'b0;
        if (req) begin
            mActive = 1'b1;
            mT      = 0;
        end else if (mActive) begin
            mT++;
            if (mT == T_DONE) begin
                mActive = 1'b0;
                mDone   = 1'b1;
            end
        end
    endtask

    // Drive one cycle of inputs from a falling edge and check at the next one
    task automatic applyStimulus(input bit k, input bit s);
        key_n      = k;
        sw_rst_req = s;
        modelStep(k, s);
        @(negedge clk);
        checkCycle();
    endtask

    task automatic doReset(input int cycles);
        rstn = 1'b0;
        modelReset();
        #1;
        checkOutput("async_rst_out", 32'(rstn_out), 32'd0);
        checkOutput("async_rst_busy", 32'(rst_busy), 32'd1);
        checkOutput("async_rst_done", 32'(rst_done), 32'd0);
        repeat (cycles) begin
            @(negedge clk);
            modelReset();
            checkCycle();
        end
        rstn = 1'b1;
    endtask

    task automatic runUntilIdle(input int maxCycles);
        int i = 0;
        while (mActive && i < maxCycles) begin
            applyStimulus(1'b1, 1'b0);
            i++;
        end
        if (mActive) checkOutput("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic runUntilOut(input logic [NS-1:0] target, input int maxCycles);
        int i = 0;
        while (expOut() != target && i < maxCycles) begin
            applyStimulus(1'b1, 1'b0);
            i++;
        end
        if (expOut() != target) checkOutput("out_timeout", 32'(expOut()), 32'(target));
    endtask

    task automatic idleFor(input int n);
        repeat (n) applyStimulus(1'b1, 1'b0);
    endtask

    initial begin
        int base;
        int n;
        bit lvl;
        rstn       = 1'b1;
        sw_rst_req = 1'b0;
        key_n      = 1'b1;
        #1;

        // Power-on: 3 cycles of reset, then a full sequence with no request
        base = doneSeen;
        doReset(3);
        runUntilIdle(50);
        idleFor(3);
        checkOutput("poweron_done_count", 32'(doneSeen - base), 32'd1);

        // Software request from idle
        base = doneSeen;
        applyStimulus(1'b1, 1'b1);
        checkOutput("sw_start_out", 32'(rstn_out), 32'd0);
        checkOutput("sw_start_busy", 32'(rst_busy), 32'd1);
        runUntilIdle(50);
        idleFor(3);
        checkOutput("sw_done_count", 32'(doneSeen - base), 32'd1);

        // Restart while two stages are released
        base = doneSeen;
        applyStimulus(1'b1, 1'b1);
        runUntilOut(3'b011, 50);
        applyStimulus(1'b1, 1'b1);
        checkOutput("restart_out", 32'(rstn_out), 32'd0);
        runUntilIdle(50);
        idleFor(3);
        checkOutput("restart_done_count", 32'(doneSeen - base), 32'd1);

        // Short key press is filtered
        base = doneSeen;
        repeat (3) applyStimulus(1'b0, 1'b0);
        idleFor(30);
        checkOutput("key_short_done_count", 32'(doneSeen - base), 32'd0);
        checkOutput("key_short_busy", 32'(rst_busy), 32'd0);

        // Long key press yields exactly one sequence
        base = doneSeen;
        repeat (20) applyStimulus(1'b0, 1'b0);
        idleFor(30);
        checkOutput("key_long_done_count", 32'(doneSeen - base), 32'd1);

        // Second press after release yields another sequence
        base = doneSeen;
        repeat (10) applyStimulus(1'b0, 1'b0);
        idleFor(30);
        checkOutput("key_again_done_count", 32'(doneSeen - base), 32'd1);

        // Reset asserted mid-sequence drops outputs at once and discards it
        base = doneSeen;
        applyStimulus(1'b1, 1'b1);
        runUntilOut(3'b001, 50);
        #2;
        doReset(2);
        checkOutput("midrst_abort_done", 32'(doneSeen - base), 32'd0);
        runUntilIdle(50);
        idleFor(3);
        checkOutput("midrst_done_count", 32'(doneSeen - base), 32'd1);

        // Software request in the very cycle the key event is accepted
        base = doneSeen;
        n = 0;
        key_n = 1'b0;
        while (!mEvt && n < 40) begin
            applyStimulus(1'b0, 1'b0);
            n++;
        end
        if (!mEvt) checkOutput("key_evt_timeout", 32'd0, 32'd1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("simul_start_out", 32'(rstn_out), 32'd0);
        repeat (20) applyStimulus(1'b0, 1'b0);
        idleFor(30);
        checkOutput("simul_done_count", 32'(doneSeen - base), 32'd1);

        // Random key activity and software requests
        for (int r = 0; r < 60; r++) begin
            lvl = 1'($urandom_range(0, 1));
            n   = $urandom_range(1, 12);
            for (int c = 0; c < n; c++) begin
                applyStimulus(lvl, ($urandom_range(0, 39) == 0));
            end
        end
        idleFor(20);
        runUntilIdle(100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rstn_seq_gen.md
RSTN_SEQ_GEN -- requirements
Module: rstn_seq_gen

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; `rstn` is externally synchronized.
REQ-002 Parameter NUM_STAGES, default 3, SHALL set the number of staged reset outputs (>=1).
REQ-003 Parameter HOLD_CYCLES, default 16, SHALL set the number of cycles all outputs stay asserted (>=1).
REQ-004 Parameter STAGE_GAP, default 8, SHALL set the number of cycles between successive stage releases (>=1).
REQ-005 Parameter DEBOUNCE_CYCLES, default 1000, SHALL set the number of stable cycles a key level needs before it is accepted (>=1).
REQ-006 Port `clk`, input, width 1, SHALL be the single clock.
REQ-007 Port `rstn`, input, width 1, SHALL be the asynchronous active-low reset.
REQ-008 Port `sw_rst_req`, input, width 1, SHALL be a one-cycle software reset request, synchronous to `clk`.
REQ-009 Port `key_n`, input, width 1, SHALL be a raw, asynchronous, active-low reset button.
REQ-010 Port `rstn_out`, output, width NUM_STAGES, SHALL carry the staged active-low resets; bit 0 is released first.
REQ-011 Port `rst_busy`, output, width 1, SHALL be high while a sequence is in progress.
REQ-012 Port `rst_done`, output, width 1, SHALL pulse for one cycle when a sequence completes.

Function
REQ-013 The FSM SHALL have three states: IDLE, ASSERT and RELEASE.
REQ-014 All `rstn_out` changes SHALL be registered, with no combinational path from inputs to `rstn_out`.
REQ-015 In ASSERT, `rstn_out` SHALL be all zeros for exactly HOLD_CYCLES cycles.
REQ-016 On the edge that ends the last ASSERT cycle, `rstn_out[0]` SHALL rise and the FSM SHALL enter RELEASE.
REQ-017 In RELEASE, `rstn_out[k]` SHALL rise exactly STAGE_GAP cycles after `rstn_out[k-1]`.
REQ-018 A released bit SHALL stay high until the next sequence or reset.
REQ-019 On the edge where `rstn_out[NUM_STAGES-1]` rises:
- the FSM SHALL enter IDLE;
- `rst_busy` SHALL fall;
- `rst_done` SHALL be high for that one following cycle only.
REQ-020 When NUM_STAGES=1, completion SHALL coincide with the rise of `rstn_out[0]`.
REQ-021 A request is `sw_rst_req`=1 or a debounced key-press event in a cycle.
REQ-022 In IDLE, a request SHALL cause, on the next edge: `rstn_out` all zeros, `rst_busy`=1, hold counter cleared, state ASSERT.
REQ-023 A request in ASSERT or RELEASE SHALL restart ASSERT on the next edge: all outputs zero, counters cleared, no `rst_done` for the aborted sequence.
REQ-024 Simultaneous software and key requests SHALL produce exactly one sequence.
REQ-025 Key debounce SHALL work as follows:
- `key_n` passes through a 2-flop synchronizer;
- the accepted level changes only after the synchronized value differs from it for DEBOUNCE_CYCLES consecutive cycles;
- any return to the accepted level clears the counter.
REQ-026 A key-press event SHALL be a 1-to-0 transition of the accepted level; holding the key SHALL NOT retrigger.
REQ-027 Counters SHALL be sized for their maximum parameter value and SHALL NOT wrap during normal operation.

Reset
REQ-028 While `rstn`=0, the block SHALL hold:
- `rstn_out`=0 asynchronously;
- `rst_busy`=1;
- `rst_done`=0;
- state ASSERT with hold counter 0;
- key synchronizer flops and accepted key level at 1, debounce counter 0.
REQ-029 After `rstn` deasserts, a full sequence SHALL run without any request; HOLD_CYCLES counts from the first edge after deassertion.
REQ-030 `rstn` asserted mid-sequence SHALL force `rstn_out` to zero immediately and SHALL discard the sequence.

Verification (NUM_STAGES=3, HOLD_CYCLES=4, STAGE_GAP=2, DEBOUNCE_CYCLES=5)
REQ-031 Power-on: `rstn` low 3 cycles, then high:
- `rstn_out`=000 for 4 cycles, then 001;
- 2 cycles later 011, 2 cycles later 111;
- `rst_done`=1 for exactly one cycle;
- `rst_busy` falls at that same edge.
REQ-032 Software request: one-cycle `sw_rst_req` in IDLE -> next edge `rstn_out`=000 and `rst_busy`=1, then the identical 4/2/2 release timeline.
REQ-033 Restart: `sw_rst_req` while `rstn_out`=011 -> next edge 000, a full 4/2/2 sequence, exactly one `rst_done` pulse in total.
REQ-034 Key debounce:
- `key_n` low for 3 cycles -> no sequence;
- `key_n` low for 20 cycles -> exactly one sequence;
- release, then press again for 10 cycles -> a second sequence.
REQ-035 Mid-sequence reset: `rstn` asserted at `rstn_out`=001 -> `rstn_out`=000 before the next edge, `rst_done` stays 0; after release, a full sequence runs.
REQ-036 Simultaneous requests: `sw_rst_req` and a key event in the same cycle -> exactly one sequence and one `rst_done`.
